// File: rtl/instr_fetch_seq_pkg.sv
// Shared definitions for the instruction fetch sequencer: class encodings,
// default per-class issue lengths and the fetch state type.
package cpu_pkg;

  localparam logic [1:0] CLS_HALT  = 2'b00;
  localparam logic [1:0] CLS_STD   = 2'b01;
  localparam logic [1:0] CLS_LOAD  = 2'b10;
  localparam logic [1:0] CLS_STORE = 2'b11;

  // Width of issue-cycle counts; counts must stay below 2**CYC_W - 1.
  localparam int unsigned CYC_W = 8;

  localparam int unsigned DEF_STD_CYCLES   = 3;
  localparam int unsigned DEF_LOAD_CYCLES  = 4;
  localparam int unsigned DEF_STORE_CYCLES = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    ISSUE = 3'd3,
    HALT  = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_seq_if.sv
// Instruction ROM read port: the sequencer is master, the ROM is slave.
interface instr_fetch_seq_if #(
  parameter int unsigned INSTR_WIDTH = 20,
  parameter int unsigned PC_BITS     = 5
);
  logic [PC_BITS-1:0]     imem_addr;
  logic                   imem_rd_en;
  logic [INSTR_WIDTH-1:0] imem_rdata;

  modport master (output imem_addr, output imem_rd_en, input imem_rdata);
  modport slave  (input imem_addr, input imem_rd_en, output imem_rdata);
endinterface

// File: rtl/instr_fetch_seq_cycle_lut.sv
// Instruction class to issue-cycle count; HALT maps to 0.
module instr_cycle_lut
  import cpu_pkg::*;
#(
  parameter int unsigned STD_CYCLES   = DEF_STD_CYCLES,
  parameter int unsigned LOAD_CYCLES  = DEF_LOAD_CYCLES,
  parameter int unsigned STORE_CYCLES = DEF_STORE_CYCLES
) (
  input  logic [1:0]       cls,
  output logic [CYC_W-1:0] cycles
);

  // The sequencer needs one prefetch cycle before each boundary.
  if (STD_CYCLES < 2 || LOAD_CYCLES < 2 || STORE_CYCLES < 2) begin : g_bad_cycles
    $error("instr_cycle_lut: every issue-cycle count must be at least 2");
  end

  always_comb begin
    cycles = '0;
    case (cls)
      CLS_STD:   cycles = CYC_W'(STD_CYCLES);
      CLS_LOAD:  cycles = CYC_W'(LOAD_CYCLES);
      CLS_STORE: cycles = CYC_W'(STORE_CYCLES);
      default:   cycles = '0;
    endcase
  end

endmodule

// File: rtl/instr_fetch_seq.sv
// Program sequencer: fetches words from a synchronous ROM and holds each on
// instr for its class's issue length, prefetching so boundaries have no bubble.
module instr_fetch_seq
  import cpu_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH  = 20,
  parameter int unsigned PC_BITS      = 5,
  parameter int unsigned STD_CYCLES   = DEF_STD_CYCLES,
  parameter int unsigned LOAD_CYCLES  = DEF_LOAD_CYCLES,
  parameter int unsigned STORE_CYCLES = DEF_STORE_CYCLES,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  instr_fetch_seq_if.master        imem,
  output logic [INSTR_WIDTH-1:0]   instr,
  output logic [PC_BITS-1:0]       pc,
  output logic                     busy,
  output logic                     halted,
  output logic [CNT_WIDTH-1:0]     retired
);

  localparam logic [PC_BITS-1:0]   PcOne  = PC_BITS'(1);
  localparam logic [CYC_W-1:0]     CycOne = CYC_W'(1);
  localparam logic [CYC_W-1:0]     CycTwo = CYC_W'(2);
  localparam logic [CNT_WIDTH-1:0] RetOne = CNT_WIDTH'(1);

  fetch_state_t     state;
  logic [CYC_W-1:0] cnt;
  logic [CYC_W-1:0] new_cycles;
  logic [1:0]       new_cls;
  logic             prefetch;

  assign new_cls = imem.imem_rdata[INSTR_WIDTH-1 -: 2];

  instr_cycle_lut #(
    .STD_CYCLES  (STD_CYCLES),
    .LOAD_CYCLES (LOAD_CYCLES),
    .STORE_CYCLES(STORE_CYCLES)
  ) u_cycle_lut (
    .cls   (new_cls),
    .cycles(new_cycles)
  );

  // Second-to-last issue cycle: read the next word so it lands at the boundary.
  assign prefetch = (state == ISSUE) && (cnt == CycTwo);

  always_comb begin
    imem.imem_rd_en = (state == FETCH) || prefetch;
    imem.imem_addr  = prefetch ? pc + PcOne : pc;
  end

  assign busy   = (state == FETCH) || (state == LOAD) || (state == ISSUE);
  assign halted = (state == HALT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      instr   <= '0;
      pc      <= '0;
      retired <= '0;
    end else begin
      case (state)
        IDLE:  if (start) state <= FETCH;
        FETCH: state <= LOAD;
        LOAD: begin
          instr <= imem.imem_rdata;
          if (new_cls == CLS_HALT) begin
            state <= HALT;
          end else begin
            state <= ISSUE;
            // Extra cycle covers the CU's exit from its reset state.
            cnt   <= new_cycles + CycOne;
          end
        end
        ISSUE: begin
          if (cnt == CycOne) begin
            instr <= imem.imem_rdata;
            pc    <= pc + PcOne;
            if (retired != '1) retired <= retired + RetOne;
            if (new_cls == CLS_HALT) state <= HALT;
            else                     cnt   <= new_cycles;
          end else begin
            cnt <= cnt - CycOne;
          end
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Randomized and directed bench for instr_fetch_seq against a hold-length model.
module tb_instr_fetch_seq;

  localparam int unsigned IW = 20;
  localparam int unsigned PB = 5;

  logic clk = 1'b0;
  logic rst;
  logic start;

  always #5 clk = ~clk;

  instr_fetch_seq_if #(.INSTR_WIDTH(IW), .PC_BITS(PB)) bus_w ();
  instr_fetch_seq_if #(.INSTR_WIDTH(IW), .PC_BITS(PB)) bus_s ();

  logic [IW-1:0] instr_w, instr_s;
  logic [PB-1:0] pc_w, pc_s;
  logic          busy_w, busy_s, halted_w, halted_s;
  logic [15:0]   ret_w;
  logic [3:0]    ret_s;

  instr_fetch_seq #(.CNT_WIDTH(16)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .imem   (bus_w),
    .instr  (instr_w),
    .pc     (pc_w),
    .busy   (busy_w),
    .halted (halted_w),
    .retired(ret_w)
  );

  instr_fetch_seq #(.CNT_WIDTH(4)) u_dut_sat (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .imem   (bus_s),
    .instr  (instr_s),
    .pc     (pc_s),
    .busy   (busy_s),
    .halted (halted_s),
    .retired(ret_s)
  );

  logic [IW-1:0] rom [32];

  always @(posedge clk) begin
    if (bus_w.imem_rd_en) bus_w.imem_rdata <= rom[bus_w.imem_addr];
    if (bus_s.imem_rd_en) bus_s.imem_rdata <= rom[bus_s.imem_addr];
  end

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: mode 0 idle, 1 starting up, 2 holding a word, 3 halted.
  int            m_mode, m_pend, m_left, m_pc, m_ret, m_ret4;
  logic [IW-1:0] m_instr;

  function automatic int hold_of(input logic [IW-1:0] w);
    logic [1:0] c;
    c = w[IW-1 -: 2];
    case (c)
      2'b01:   return 3;
      2'b10:   return 4;
      2'b11:   return 3;
      default: return 0;
    endcase
  endfunction

  task automatic present(input int extra);
    int h;
    m_instr = rom[m_pc];
    h = hold_of(m_instr);
    if (h == 0) m_mode = 3;
    else begin
      m_mode = 2;
      m_left = h + extra;
    end
  endtask

  task automatic model_update();
    if (!rst) begin
      m_mode = 0; m_pend = 0; m_left = 0; m_pc = 0; m_ret = 0; m_ret4 = 0; m_instr = '0;
    end else begin
      case (m_mode)
        0: if (start) begin m_mode = 1; m_pend = 2; end
        1: begin
          m_pend--;
          if (m_pend == 0) present(1);
        end
        2: begin
          m_left--;
          if (m_left == 0) begin
            m_pc   = (m_pc + 1) % 32;
            m_ret  = (m_ret < 65535) ? m_ret + 1 : m_ret;
            m_ret4 = (m_ret4 < 15) ? m_ret4 + 1 : m_ret4;
            present(0);
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    logic exp_rd;
    int   exp_addr;
    exp_rd   = (m_mode == 1 && m_pend == 2) || (m_mode == 2 && m_left == 2);
    exp_addr = (m_mode == 2) ? (m_pc + 1) % 32 : m_pc;
    check_eq("instr",   32'(instr_w), 32'(m_instr));
    check_eq("pc",      32'(pc_w), 32'(m_pc));
    check_eq("busy",    32'(busy_w), 32'(m_mode == 1 || m_mode == 2));
    check_eq("halted",  32'(halted_w), 32'(m_mode == 3));
    check_eq("retired", 32'(ret_w), 32'(m_ret));
    check_eq("rd_en",   32'(bus_w.imem_rd_en), 32'(exp_rd));
    if (exp_rd) check_eq("rd_addr", 32'(bus_w.imem_addr), 32'(exp_addr));
    check_eq("sat_instr",   32'(instr_s), 32'(m_instr));
    check_eq("sat_retired", 32'(ret_s), 32'(m_ret4));
    check_eq("sat_rd_en",   32'(bus_s.imem_rd_en), 32'(exp_rd));
  endtask

  // Inputs change on the falling edge; outputs are compared there too.
  task automatic step(input logic r, input logic s);
    rst   = r;
    start = s;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = '0;
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    clear_rom();
    @(negedge clk);
    step(1'b0, 1'b1);  // start coincident with reset: reset wins
    step(1'b0, 1'b0);

    // Single std instruction followed by HALT.
    rom[0] = 20'h4_1003;
    rom[1] = 20'h0_0000;
    step(1'b1, 1'b1);
    repeat (9) step(1'b1, 1'b0);
    check_eq("t2_halt_pc", 32'(pc_w), 32'd1);
    check_eq("t2_halt_ret", 32'(ret_w), 32'd1);

    // std/load/store/halt with start pulsed every cycle; then mid-issue reset.
    rom[0] = 20'h4_1003;
    rom[1] = 20'h8_5014;
    rom[2] = 20'hC_5024;
    rom[3] = 20'h0_0000;
    step(1'b0, 1'b0);
    repeat (20) step(1'b1, 1'b1);
    check_eq("t3_ret", 32'(ret_w), 32'd3);
    check_eq("t3_pc", 32'(pc_w), 32'd3);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    repeat (7) step(1'b1, 1'b0);
    check_eq("t1_in_load", 32'(instr_w), 32'h8_5014);
    step(1'b0, 1'b0);
    check_eq("t1_rst_instr", 32'(instr_w), 32'd0);
    check_eq("t1_rst_busy", 32'(busy_w), 32'd0);
    check_eq("t1_rst_rd", 32'(bus_w.imem_rd_en), 32'd0);

    // HALT at address 0.
    rom[0] = 20'h0_1234;
    step(1'b1, 1'b1);
    repeat (4) step(1'b1, 1'b0);
    check_eq("halt0_ret", 32'(ret_w), 32'd0);
    check_eq("halt0_halted", 32'(halted_w), 32'd1);

    // All-std program: PC wrap and counter saturation on the narrow instance.
    step(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) rom[i] = {2'b01, 18'($urandom)};
    step(1'b1, 1'b1);
    repeat (320) step(1'b1, $urandom_range(0, 3) == 0);
    check_eq("wrap_sat", 32'(ret_s), 32'hF);
    check_eq("wrap_ret_gt32", 32'(ret_w > 16'd32), 32'd1);

    // Random programs, random start pulses and occasional resets.
    for (int r = 0; r < 20; r++) begin
      step(1'b0, 1'b0);
      for (int i = 0; i < 32; i++) begin
        logic [1:0] c;
        c = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'(($urandom_range(1, 3)));
        rom[i] = {c, 18'($urandom)};
      end
      for (int k = 0; k < 150; k++)
        step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
